// File: rtl/bbox_multi_tracker.sv
// bbox_multi_tracker: non-blocking tap on a 24-bit RGB video stream.
// - Classifies each pixel against N_CH programmable RGB windows.
// - Run-length filters each channel per row.
// - Tracks one bounding box per channel.
// - Every MSG_INTERVAL video frames, queues a box report in a message FIFO
//   that is read over the Avalon-MM slave.
// Optional feature macro: BBOX_PIXCOUNT_EN adds a per-channel qualified
// pixel counter and a CNT word after each channel's BR word.
module bbox_multi_tracker #(
    parameter int IMAGE_W      = 640,
    parameter int IMAGE_H      = 480,
    parameter int N_CH         = 4,
    parameter int RUN_LEN      = 5,
    parameter int MSG_INTERVAL = 6,
    parameter int MSG_DEPTH    = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_chipselect,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [4:0]  s_address,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    input  logic [23:0] sink_data,
    input  logic        sink_valid,
    input  logic        sink_sop,
    input  logic        sink_eop,
    output logic        sink_ready
);
    localparam int AW = $clog2(MSG_DEPTH);
    localparam int RW = $clog2(RUN_LEN + 1);
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
`ifdef BBOX_PIXCOUNT_EN
    localparam int WPR = 1 + 3 * N_CH;
`else
    localparam int WPR = 1 + 2 * N_CH;
`endif
    localparam logic [10:0] X_EMPTY  = 11'(IMAGE_W - 1);
    localparam logic [10:0] Y_EMPTY  = 11'(IMAGE_H - 1);
    localparam logic [AW:0] ROOM_MAX = (AW + 1)'(MSG_DEPTH - WPR);
    localparam logic [AW:0] FULL     = (AW + 1)'(MSG_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_TL,
`ifdef BBOX_PIXCOUNT_EN
        S_CNT,
`endif
        S_BR
    } state_t;

    logic          enable, skip;
    logic [23:0]   lo_r [N_CH];
    logic [23:0]   hi_r [N_CH];
    logic          in_video;
    logic [10:0]   pix_x, pix_y;
    logic          pix_beat, vid_eop, room, start_report, skip_set;
    logic [N_CH-1:0] match, qual;
    logic [RW-1:0] run_r [N_CH];
    logic [RW-1:0] run_nxt [N_CH];
    logic [10:0]   box_xmin [N_CH], box_xmax [N_CH], box_ymin [N_CH], box_ymax [N_CH];
    logic [10:0]   nxt_xmin [N_CH], nxt_xmax [N_CH], nxt_ymin [N_CH], nxt_ymax [N_CH];
    logic [10:0]   sh_xmin [N_CH], sh_xmax [N_CH], sh_ymin [N_CH], sh_ymax [N_CH];
`ifdef BBOX_PIXCOUNT_EN
    logic [19:0]   pcnt [N_CH], pcnt_nxt [N_CH], sh_pcnt [N_CH];
`endif
    logic [7:0]    frame_seq, frame_cnt, sh_seq;
    state_t        state, state_nxt;
    logic [CW-1:0] ch, ch_nxt;
    logic          fsm_wr, fifo_we, pop, flush;
    logic [31:0]   fsm_wdata, rd_value;
    logic [31:0]   fifo_mem [MSG_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_used;
    logic          rd_req, rd_prev, rd_start, wr_req;

    assign sink_ready   = 1'b1;
    assign pix_beat     = sink_valid && !sink_sop && in_video;
    assign vid_eop      = pix_beat && sink_eop;
    assign room         = fifo_used <= ROOM_MAX;
    assign start_report = vid_eop && (frame_cnt == 8'd0) && (state == S_IDLE) && room;
    assign skip_set     = vid_eop && (frame_cnt == 8'd0) && (state == S_IDLE) && !room;
    assign rd_req       = s_chipselect && s_read;
    assign rd_start     = rd_req && !rd_prev;
    assign wr_req       = s_chipselect && s_write;
    assign flush        = wr_req && (s_address == 5'd0) && s_writedata[4];
    assign pop          = rd_start && (s_address == 5'd1) && (fifo_used != '0);
    assign fifo_we      = fsm_wr && !flush && (fifo_used != FULL);

    // Per-channel window match, run filter and next box value for this beat
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            match[c] = enable &&
                       (sink_data[23:16] >= lo_r[c][23:16]) && (sink_data[23:16] <= hi_r[c][23:16]) &&
                       (sink_data[15:8]  >= lo_r[c][15:8])  && (sink_data[15:8]  <= hi_r[c][15:8])  &&
                       (sink_data[7:0]   >= lo_r[c][7:0])   && (sink_data[7:0]   <= hi_r[c][7:0]);
            run_nxt[c]  = run_r[c];
            qual[c]     = 1'b0;
            nxt_xmin[c] = box_xmin[c];
            nxt_xmax[c] = box_xmax[c];
            nxt_ymin[c] = box_ymin[c];
            nxt_ymax[c] = box_ymax[c];
`ifdef BBOX_PIXCOUNT_EN
            pcnt_nxt[c] = pcnt[c];
`endif
            if (pix_beat) begin
                if (!match[c])
                    run_nxt[c] = '0;
                else if (pix_x == 11'd0)
                    run_nxt[c] = RW'(1);
                else if (run_r[c] != RW'(RUN_LEN))
                    run_nxt[c] = run_r[c] + 1'b1;
                qual[c] = match[c] && (run_nxt[c] == RW'(RUN_LEN));
                if (qual[c]) begin
                    if (pix_x < box_xmin[c]) nxt_xmin[c] = pix_x;
                    if (pix_x > box_xmax[c]) nxt_xmax[c] = pix_x;
                    if (pix_y < box_ymin[c]) nxt_ymin[c] = pix_y;
                    nxt_ymax[c] = pix_y;
`ifdef BBOX_PIXCOUNT_EN
                    if (pcnt[c] != 20'hFFFFF) pcnt_nxt[c] = pcnt[c] + 20'd1;
`endif
                end
            end
        end
    end

    // Raster position, run counters and live boxes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_video <= 1'b0;
            pix_x    <= '0;
            pix_y    <= '0;
            for (int c = 0; c < N_CH; c++) begin
                run_r[c]    <= '0;
                box_xmin[c] <= X_EMPTY;
                box_ymin[c] <= Y_EMPTY;
                box_xmax[c] <= '0;
                box_ymax[c] <= '0;
`ifdef BBOX_PIXCOUNT_EN
                pcnt[c]     <= '0;
`endif
            end
        end else if (sink_valid && sink_sop) begin
            in_video <= (sink_data[3:0] == 4'd0);
            pix_x    <= '0;
            pix_y    <= '0;
            for (int c = 0; c < N_CH; c++) begin
                run_r[c] <= '0;
                if (sink_data[3:0] == 4'd0) begin
                    box_xmin[c] <= X_EMPTY;
                    box_ymin[c] <= Y_EMPTY;
                    box_xmax[c] <= '0;
                    box_ymax[c] <= '0;
`ifdef BBOX_PIXCOUNT_EN
                    pcnt[c]     <= '0;
`endif
                end
            end
        end else if (pix_beat) begin
            if (pix_x == X_EMPTY) begin
                pix_x <= '0;
                pix_y <= pix_y + 11'd1;
            end else begin
                pix_x <= pix_x + 11'd1;
            end
            for (int c = 0; c < N_CH; c++) begin
                run_r[c]    <= run_nxt[c];
                box_xmin[c] <= nxt_xmin[c];
                box_xmax[c] <= nxt_xmax[c];
                box_ymin[c] <= nxt_ymin[c];
                box_ymax[c] <= nxt_ymax[c];
`ifdef BBOX_PIXCOUNT_EN
                pcnt[c]     <= pcnt_nxt[c];
`endif
            end
        end
    end

    // Frame bookkeeping; shadow takes the boxes including the eop pixel
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_seq <= '0;
            frame_cnt <= '0;
            sh_seq    <= '0;
            for (int c = 0; c < N_CH; c++) begin
                sh_xmin[c] <= X_EMPTY;
                sh_ymin[c] <= Y_EMPTY;
                sh_xmax[c] <= '0;
                sh_ymax[c] <= '0;
`ifdef BBOX_PIXCOUNT_EN
                sh_pcnt[c] <= '0;
`endif
            end
        end else if (vid_eop) begin
            frame_seq <= frame_seq + 8'd1;
            if (start_report) begin
                frame_cnt <= 8'(MSG_INTERVAL - 1);
                sh_seq    <= frame_seq + 8'd1;
                for (int c = 0; c < N_CH; c++) begin
                    sh_xmin[c] <= nxt_xmin[c];
                    sh_xmax[c] <= nxt_xmax[c];
                    sh_ymin[c] <= nxt_ymin[c];
                    sh_ymax[c] <= nxt_ymax[c];
`ifdef BBOX_PIXCOUNT_EN
                    sh_pcnt[c] <= pcnt_nxt[c];
`endif
                end
            end else if (!((frame_cnt == 8'd0) && (state == S_IDLE))) begin
                frame_cnt <= frame_cnt - 8'd1;
            end
        end
    end

    // Report FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            ch    <= '0;
        end else begin
            state <= state_nxt;
            ch    <= ch_nxt;
        end
    end

    // Report FSM next state: HDR, then TL/BR[/CNT] per channel
    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        case (state)
            S_IDLE: if (start_report) begin
                state_nxt = S_HDR;
                ch_nxt    = '0;
            end
            S_HDR: state_nxt = S_TL;
            S_TL:  state_nxt = S_BR;
`ifdef BBOX_PIXCOUNT_EN
            S_BR:  state_nxt = S_CNT;
            S_CNT: begin
`else
            S_BR: begin
`endif
                if (ch == CW'(N_CH - 1)) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_TL;
                    ch_nxt    = ch + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Report FSM output: one FIFO word per busy cycle
    always_comb begin
        fsm_wr    = 1'b0;
        fsm_wdata = '0;
        case (state)
            S_HDR: begin
                fsm_wr    = 1'b1;
                fsm_wdata = {16'h4242, 8'(N_CH), sh_seq};
            end
            S_TL: begin
                fsm_wr    = 1'b1;
                fsm_wdata = {5'b0, sh_xmin[ch], 5'b0, sh_ymin[ch]};
            end
            S_BR: begin
                fsm_wr    = 1'b1;
                fsm_wdata = {5'b0, sh_xmax[ch], 5'b0, sh_ymax[ch]};
            end
`ifdef BBOX_PIXCOUNT_EN
            S_CNT: begin
                fsm_wr    = 1'b1;
                fsm_wdata = {12'b0, sh_pcnt[ch]};
            end
`endif
            default: ;
        endcase
    end

    // Message FIFO storage
    always_ff @(posedge clk) begin
        if (fifo_we) fifo_mem[wr_ptr] <= fsm_wdata;
    end

    // Message FIFO pointers; flush beats any same-cycle write or pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_used <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_used <= '0;
        end else begin
            if (fifo_we) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({fifo_we, pop})
                2'b10:   fifo_used <= fifo_used + 1'b1;
                2'b01:   fifo_used <= fifo_used - 1'b1;
                default: ;
            endcase
        end
    end

    // Register read mux
    always_comb begin
        rd_value = '0;
        case (s_address)
            5'd0: rd_value = {8'd0, 16'(fifo_used), 6'd0, skip, enable};
            5'd1: rd_value = (fifo_used != '0) ? fifo_mem[rd_ptr] : 32'd0;
            5'd2: rd_value = 32'h1234EEE3;
            default: begin
                for (int c = 0; c < N_CH; c++) begin
                    if (s_address == 5'(4 + 2 * c)) rd_value = {8'd0, lo_r[c]};
                    if (s_address == 5'(5 + 2 * c)) rd_value = {8'd0, hi_r[c]};
                end
            end
        endcase
    end

    // Register file writes, sticky skip and registered read data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable     <= 1'b1;
            skip       <= 1'b0;
            rd_prev    <= 1'b0;
            s_readdata <= '0;
            for (int c = 0; c < N_CH; c++) begin
                lo_r[c] <= 24'hFFFFFF;
                hi_r[c] <= 24'h000000;
            end
        end else begin
            rd_prev <= rd_req;
            if (skip_set)
                skip <= 1'b1;
            else if (wr_req && (s_address == 5'd0) && s_writedata[1])
                skip <= 1'b0;
            if (wr_req) begin
                if (s_address == 5'd0) enable <= s_writedata[0];
                for (int c = 0; c < N_CH; c++) begin
                    if (s_address == 5'(4 + 2 * c)) lo_r[c] <= s_writedata[23:0];
                    if (s_address == 5'(5 + 2 * c)) hi_r[c] <= s_writedata[23:0];
                end
            end
            // a held READ_MSG strobe keeps the word it popped
            if (rd_req && ((s_address != 5'd1) || rd_start))
                s_readdata <= rd_value;
        end
    end

endmodule
